// File: rtl/regfile_rat.sv
// Architectural register file merged with a register alias table: committed data,
// busy bit and youngest-producer ROB tag per register, with combinational operand lookup.
module regfile_rat #(
  parameter int WIDTH        = 32,
  parameter int NUM_REGS     = 32,
  parameter int ROB_DEPTH    = 8,
  parameter int READ_PORTS   = 2,
  parameter int COMMIT_PORTS = 2,
  localparam int RW = $clog2(NUM_REGS),
  localparam int TW = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [RW-1:0]    disp_rd,
  input  logic [TW-1:0]    disp_tag,
  input  logic             cmt_valid [COMMIT_PORTS],
  input  logic [RW-1:0]    cmt_rd    [COMMIT_PORTS],
  input  logic [TW-1:0]    cmt_tag   [COMMIT_PORTS],
  input  logic [WIDTH-1:0] cmt_data  [COMMIT_PORTS],
  input  logic             rob_rdy   [ROB_DEPTH],
  input  logic [WIDTH-1:0] rob_data  [ROB_DEPTH],
  input  logic [RW-1:0]    rs_idx    [READ_PORTS],
  output logic             rs_busy   [READ_PORTS],
  output logic [TW-1:0]    rs_tag    [READ_PORTS],
  output logic [WIDTH-1:0] rs_val    [READ_PORTS]
);

  localparam int LW = 1 + TW + WIDTH;

  logic [WIDTH-1:0] data_q [NUM_REGS];
  logic [WIDTH-1:0] data_d [NUM_REGS];
  logic             busy_q [NUM_REGS];
  logic             busy_d [NUM_REGS];
  logic [TW-1:0]    tag_q  [NUM_REGS];
  logic [TW-1:0]    tag_d  [NUM_REGS];

  // Operand lookup on pre-update state; packs {busy, tag, val}.
  function automatic logic [LW-1:0] lookup(input logic [RW-1:0] idx);
    logic             hit;
    logic [WIDTH-1:0] fwd;
    logic [TW-1:0]    t;
    hit = 1'b0;
    fwd = '0;
    t   = tag_q[idx];
    if (idx == '0) begin
      return '0;
    end
    if (!busy_q[idx]) begin
      return {1'b0, t, data_q[idx]};
    end
    // Ascending scan so the youngest matching commit port wins.
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      if (cmt_valid[i] && cmt_rd[i] == idx && cmt_tag[i] == t) begin
        hit = 1'b1;
        fwd = cmt_data[i];
      end
    end
    if (hit) begin
      return {1'b0, t, fwd};
    end
    if (rob_rdy[t]) begin
      return {1'b0, t, rob_data[t]};
    end
    return {1'b1, t, {WIDTH{1'b0}}};
  endfunction

  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      {rs_busy[p], rs_tag[p], rs_val[p]} = lookup(rs_idx[p]);
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      data_d[r] = data_q[r];
      busy_d[r] = busy_q[r];
      tag_d[r]  = tag_q[r];
    end
    // Stale-tag commits still write data; only the owning producer releases busy.
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      if (cmt_valid[i] && cmt_rd[i] != '0) begin
        data_d[cmt_rd[i]] = cmt_data[i];
        if (busy_q[cmt_rd[i]] && tag_q[cmt_rd[i]] == cmt_tag[i]) begin
          busy_d[cmt_rd[i]] = 1'b0;
        end
      end
    end
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        busy_d[r] = 1'b0;
      end
    end else if (disp_valid && disp_rd != '0) begin
      busy_d[disp_rd] = 1'b1;
      tag_d[disp_rd]  = disp_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
        busy_q[r] <= 1'b0;
        tag_q[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= data_d[r];
        busy_q[r] <= busy_d[r];
        tag_q[r]  <= tag_d[r];
      end
    end
  end

endmodule

// File: tb/tb_regfile_rat.sv
// Randomised scoreboard bench for regfile_rat against a behavioural rename-table model.
module tb_regfile_rat;
  localparam int W = 32, NR = 32, RD = 8, RP = 2, CP = 2, RW = 5, TW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, disp_valid;
  logic [RW-1:0] disp_rd;
  logic [TW-1:0] disp_tag;
  logic          cmt_valid [CP];
  logic [RW-1:0] cmt_rd    [CP];
  logic [TW-1:0] cmt_tag   [CP];
  logic [W-1:0]  cmt_data  [CP];
  logic          rob_rdy   [RD];
  logic [W-1:0]  rob_data  [RD];
  logic [RW-1:0] rs_idx    [RP];
  logic          rs_busy   [RP];
  logic [TW-1:0] rs_tag    [RP];
  logic [W-1:0]  rs_val    [RP];

  regfile_rat #(.WIDTH(W), .NUM_REGS(NR), .ROB_DEPTH(RD), .READ_PORTS(RP),
                .COMMIT_PORTS(CP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .disp_valid(disp_valid),
    .disp_rd(disp_rd), .disp_tag(disp_tag), .cmt_valid(cmt_valid),
    .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
    .rob_rdy(rob_rdy), .rob_data(rob_data), .rs_idx(rs_idx),
    .rs_busy(rs_busy), .rs_tag(rs_tag), .rs_val(rs_val));

  // Reference model state
  logic [W-1:0]  m_data [NR];
  logic          m_busy [NR];
  logic [TW-1:0] m_tag  [NR];

  typedef struct {
    int            port;
    int            reg_no;
    logic          busy;
    logic [TW-1:0] tag;
    logic [W-1:0]  val;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   checks = 0;
  int   fails  = 0;

  always @(negedge clk) begin
    while (expq.size() > 0) begin
      me = expq.pop_front();
      checks++;
      if (rs_busy[me.port] !== me.busy || rs_tag[me.port] !== me.tag ||
          rs_val[me.port] !== me.val) begin
        fails++;
        $display("FAIL read p%0d x%0d: got busy=%0b tag=%0d val=%h, expected busy=%0b tag=%0d val=%h",
                 me.port, me.reg_no, rs_busy[me.port], rs_tag[me.port], rs_val[me.port],
                 me.busy, me.tag, me.val);
      end
    end
  end

  task automatic model_read(input int r, output logic b, output logic [TW-1:0] t,
                            output logic [W-1:0] v);
    bit found = 0;
    b = 1'b0; t = '0; v = '0;
    if (r == 0) return;
    t = m_tag[r];
    if (!m_busy[r]) begin
      v = m_data[r];
      return;
    end
    for (int i = CP - 1; i >= 0; i--) begin
      if (!found && cmt_valid[i] && int'(cmt_rd[i]) == r && cmt_tag[i] == m_tag[r]) begin
        v = cmt_data[i];
        found = 1;
      end
    end
    if (found) return;
    if (rob_rdy[m_tag[r]]) v = rob_data[m_tag[r]];
    else b = 1'b1;
  endtask

  task automatic model_update();
    bit wrote, clr;
    if (rst) begin
      for (int r = 0; r < NR; r++) begin
        m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
      return;
    end
    for (int r = 1; r < NR; r++) begin
      wrote = 0; clr = 0;
      for (int i = CP - 1; i >= 0; i--) begin
        if (cmt_valid[i] && int'(cmt_rd[i]) == r) begin
          if (!wrote) m_data[r] = cmt_data[i];
          wrote = 1;
          if (m_busy[r] && cmt_tag[i] == m_tag[r]) clr = 1;
        end
      end
      if (clr) m_busy[r] = 1'b0;
      if (flush) m_busy[r] = 1'b0;
      else if (disp_valid && int'(disp_rd) == r) begin
        m_busy[r] = 1'b1;
        m_tag[r]  = disp_tag;
      end
    end
  endtask

  task automatic step();
    exp_t e;
    if (!rst) begin
      for (int p = 0; p < RP; p++) begin
        e.port = p;
        e.reg_no = int'(rs_idx[p]);
        model_read(int'(rs_idx[p]), e.busy, e.tag, e.val);
        expq.push_back(e);
      end
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; disp_valid = 0; disp_rd = '0; disp_tag = '0;
    for (int i = 0; i < CP; i++) begin
      cmt_valid[i] = 0; cmt_rd[i] = '0; cmt_tag[i] = '0; cmt_data[i] = '0;
    end
    for (int k = 0; k < RD; k++) begin
      rob_rdy[k] = 0; rob_data[k] = $urandom;
    end
    for (int p = 0; p < RP; p++) rs_idx[p] = '0;
  endtask

  task automatic commit(input int port, input int rd, input int tag, input logic [W-1:0] d);
    cmt_valid[port] = 1; cmt_rd[port] = RW'(rd); cmt_tag[port] = TW'(tag); cmt_data[port] = d;
  endtask

  task automatic dispatch(input int rd, input int tag);
    disp_valid = 1; disp_rd = RW'(rd); disp_tag = TW'(tag);
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    step(); step();
    // Reset state on all ports
    idle(); rs_idx[0] = 5; rs_idx[1] = 0; step();
    idle(); rs_idx[0] = 31; rs_idx[1] = 12; step();
    // Commit to a non-busy register
    idle(); commit(0, 5, 3, 32'hDEAD_BEEF); step();
    idle(); rs_idx[0] = 5; step();
    // Dispatch then ROB forwarding
    idle(); dispatch(7, 2); step();
    idle(); rs_idx[0] = 7; step();
    idle(); rob_rdy[2] = 1; rob_data[2] = 32'h55; rs_idx[0] = 7; rs_idx[1] = 7; step();
    // Commit forwarding and dispatch overriding busy clear
    idle(); commit(0, 7, 2, 32'h11); dispatch(7, 5); rs_idx[0] = 7; step();
    idle(); rs_idx[0] = 7; step();
    // Stale producer commit
    idle(); dispatch(3, 4); step();
    idle(); commit(1, 3, 1, 32'h99); rs_idx[0] = 3; step();
    idle(); rs_idx[0] = 3; step();
    // Flush with same-cycle dispatch
    idle(); dispatch(1, 6); step();
    idle(); dispatch(2, 7); rs_idx[0] = 1; step();
    idle(); flush = 1; dispatch(4, 0); rs_idx[0] = 1; rs_idx[1] = 2; step();
    idle(); rs_idx[0] = 1; rs_idx[1] = 2; step();
    idle(); rs_idx[0] = 4; rs_idx[1] = 7; step();
    idle(); rs_idx[0] = 3; step();
    // Register 0 and same-register multi-commit
    idle(); dispatch(0, 3); commit(0, 0, 3, 32'hFFFF); rs_idx[0] = 0; step();
    idle(); rs_idx[0] = 0; step();
    idle(); commit(0, 9, 0, 32'hA); commit(1, 9, 1, 32'hB); step();
    idle(); rs_idx[0] = 9; step();
    // Randomised traffic over a small register window to force collisions
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 1) == 1) dispatch($urandom_range(0, 7), $urandom_range(0, RD - 1));
      for (int i = 0; i < CP; i++) begin
        if ($urandom_range(0, 1) == 1)
          commit(i, $urandom_range(0, 7), $urandom_range(0, RD - 1), $urandom);
      end
      for (int k = 0; k < RD; k++) rob_rdy[k] = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < RP; p++)
        rs_idx[p] = ($urandom_range(0, 9) == 0) ? RW'($urandom_range(0, NR - 1))
                                               : RW'($urandom_range(0, 7));
      step();
    end
    idle();
    repeat (2) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
